// File: rtl/mem_stage_wb_reg_pkg.sv
// Shared types and constants for the data-memory stage and its DM/WB register.
// Holds the FSM encoding, the DM/WB field bundle and the bubble value.
package dm_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_t;

   localparam int WORD_BYTES = 4;
   localparam int WORD_BITS  = 8 * WORD_BYTES;
   localparam int OFFS_BITS  = $clog2(WORD_BYTES);

   typedef struct packed {
      logic [WORD_BITS-1:0] read_data;
      logic [31:0]          alu_result;
      logic [4:0]           rd;
      logic                 mem_to_reg;
      logic                 reg_write;
      logic                 misaligned;
   } wb_t;

   // Captured into DM/WB while an access is still waiting, so WB does nothing.
   localparam wb_t WB_BUBBLE = '{
      read_data:  '0,
      alu_result: 32'h0,
      rd:         5'd0,
      mem_to_reg: 1'b0,
      reg_write:  1'b0,
      misaligned: 1'b0
   };

   function automatic logic is_aligned(input logic [OFFS_BITS-1:0] offs);
      return offs == '0;
   endfunction

endpackage

// File: rtl/mem_stage_wb_reg_if.sv
// EX/DM inputs and DM/WB outputs of the data-memory stage.
// master = pipeline side driving the request; slave = the DM stage.
interface mem_stage_wb_reg_if;

   logic        mem_read_in;
   logic        mem_write_in;
   logic        mem_to_reg_in;
   logic        reg_write_in;
   logic [4:0]  rd_in;
   logic [31:0] mem_addr_in;
   logic [31:0] write_data_in;

   logic        stall_out;
   logic [31:0] read_data_out;
   logic [31:0] alu_result_out;
   logic [4:0]  rd_out;
   logic        mem_to_reg_out;
   logic        reg_write_out;
   logic        misaligned_out;

   modport master (
      output mem_read_in, mem_write_in, mem_to_reg_in, reg_write_in,
             rd_in, mem_addr_in, write_data_in,
      input  stall_out, read_data_out, alu_result_out, rd_out,
             mem_to_reg_out, reg_write_out, misaligned_out
   );

   modport slave (
      input  mem_read_in, mem_write_in, mem_to_reg_in, reg_write_in,
             rd_in, mem_addr_in, write_data_in,
      output stall_out, read_data_out, alu_result_out, rd_out,
             mem_to_reg_out, reg_write_out, misaligned_out
   );

endinterface

// File: rtl/mem_stage_wb_reg_sram.sv
// Word-wide data memory: synchronous write, combinational read.
import dm_pkg::*;

module dm_sram #(
   parameter int DEPTH_WORDS = 256,
   parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
   input  logic                 clk,
   input  logic                 we,
   input  logic [ADDR_W-1:0]    addr,
   input  logic [WORD_BITS-1:0] wdata,
   output logic [WORD_BITS-1:0] rdata
);

   logic [WORD_BITS-1:0] mem [DEPTH_WORDS];

   // NOTE: no reset on the array; contents survive reset and it maps onto plain RAM.
   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage_wb_reg.sv
// Data-memory pipeline stage: word access with WAIT_STATES extra cycles,
// upstream stall while busy, and the DM/WB pipeline register.
import dm_pkg::*;

module mem_stage_wb_reg #(
   parameter int DEPTH_WORDS = 256,
   parameter int WAIT_STATES = 2
) (
   input  logic                clk,
   input  logic                reset,
   mem_stage_wb_reg_if.slave   bus
);

   localparam int         ADDR_W   = $clog2(DEPTH_WORDS);
   localparam logic [2:0] CNT_INIT = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

   state_t      state, state_nx;
   logic [2:0]  cnt, cnt_nx;
   wb_t         wb_q, wb_nx, wb_done;
   logic        request, aligned, access, misaligned;
   logic        stall, complete, we;
   logic [WORD_BITS-1:0] rdata;

   dm_sram #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .ADDR_W      (ADDR_W)
   ) u_sram (
      .clk   (clk),
      .we    (we),
      .addr  (bus.mem_addr_in[ADDR_W+1:2]),
      .wdata (bus.write_data_in),
      .rdata (rdata)
   );

   always_comb begin
      request    = bus.mem_read_in | bus.mem_write_in;
      aligned    = is_aligned(bus.mem_addr_in[OFFS_BITS-1:0]);
      access     = request & aligned;
      misaligned = request & ~aligned;

      // Read-before-write: load data comes from the array ahead of any store.
      wb_done.read_data  = (access && bus.mem_read_in) ? rdata : '0;
      wb_done.alu_result = bus.mem_addr_in;
      wb_done.rd         = bus.rd_in;
      wb_done.mem_to_reg = bus.mem_to_reg_in;
      wb_done.reg_write  = bus.reg_write_in & ~misaligned;
      wb_done.misaligned = misaligned;
   end

   always_comb begin
      // NOTE: every output of this block gets a default first so no latch is inferred.
      state_nx = state;
      cnt_nx   = cnt;
      stall    = 1'b0;
      complete = 1'b0;
      wb_nx    = WB_BUBBLE;
      we       = 1'b0;

      unique case (state)
         IDLE: begin
            if (access && (WAIT_STATES > 0)) begin
               stall    = 1'b1;
               state_nx = WAIT;
               cnt_nx   = CNT_INIT;
            end else begin
               complete = 1'b1;
            end
         end
         WAIT: begin
            if (cnt != 3'd0) begin
               stall  = 1'b1;
               cnt_nx = cnt - 3'd1;
            end else begin
               complete = 1'b1;
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase

      if (complete) begin
         wb_nx = wb_done;
         we    = access & bus.mem_write_in & ~reset;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= 3'd0;
         wb_q  <= WB_BUBBLE;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         wb_q  <= wb_nx;
      end
   end

   assign bus.stall_out      = stall;
   assign bus.read_data_out  = wb_q.read_data;
   assign bus.alu_result_out = wb_q.alu_result;
   assign bus.rd_out         = wb_q.rd;
   assign bus.mem_to_reg_out = wb_q.mem_to_reg;
   assign bus.reg_write_out  = wb_q.reg_write;
   assign bus.misaligned_out = wb_q.misaligned;

endmodule

// File: tb/tb_mem_stage_wb_reg.sv
// Scoreboard bench for mem_stage_wb_reg: the driver queues the expected DM/WB
// contents for every cycle, a monitor compares after each rising edge.
module tb_mem_stage_wb_reg;

   localparam int WS = 2;

   typedef struct {
      string       tag;
      logic        stall;
      logic        chk_alu;
      logic        chk_rdata;
      logic [31:0] read_data;
      logic [31:0] alu_result;
      logic [4:0]  rd;
      logic        mem_to_reg;
      logic        reg_write;
      logic        misaligned;
   } item_t;

   logic  clk = 1'b0;
   logic  reset;
   int    n_checks = 0;
   int    n_errors = 0;
   item_t q[$];

   mem_stage_wb_reg_if bus ();

   mem_stage_wb_reg #(
      .DEPTH_WORDS (256),
      .WAIT_STATES (WS)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Combinational stall is sampled mid-cycle, DM/WB just after the edge.
   initial begin : monitor
      item_t it;
      logic  s;
      forever begin
         @(negedge clk);
         s = bus.stall_out;
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            it = q.pop_front();
            check({it.tag, ".stall"}, 32'(s), 32'(it.stall));
            if (it.chk_rdata) check({it.tag, ".read_data"}, bus.read_data_out, it.read_data);
            if (it.chk_alu)   check({it.tag, ".alu_result"}, bus.alu_result_out, it.alu_result);
            check({it.tag, ".rd"},         32'(bus.rd_out),         32'(it.rd));
            check({it.tag, ".mem_to_reg"}, 32'(bus.mem_to_reg_out), 32'(it.mem_to_reg));
            check({it.tag, ".reg_write"},  32'(bus.reg_write_out),  32'(it.reg_write));
            check({it.tag, ".misaligned"}, 32'(bus.misaligned_out), 32'(it.misaligned));
         end
      end
   end

   task automatic drive(input logic rd_en, input logic wr_en, input logic m2r, input logic rw,
                        input logic [4:0] rd, input logic [31:0] addr, input logic [31:0] wdata);
      bus.mem_read_in   = rd_en;
      bus.mem_write_in  = wr_en;
      bus.mem_to_reg_in = m2r;
      bus.reg_write_in  = rw;
      bus.rd_in         = rd;
      bus.mem_addr_in   = addr;
      bus.write_data_in = wdata;
   endtask

   task automatic push_bubble(input string tag);
      item_t b;
      b = '{tag: tag, stall: 1'b1, chk_alu: 1'b0, chk_rdata: 1'b1, read_data: 32'h0,
            alu_result: 32'h0, rd: 5'd0, mem_to_reg: 1'b0, reg_write: 1'b0, misaligned: 1'b0};
      q.push_back(b);
   endtask

   // One instruction; starts and ends just after a rising edge. Expected
   // fields are hand-computed by the caller; stall count follows alignment.
   task automatic issue(input string tag, input logic rd_en, input logic wr_en,
                        input logic m2r, input logic rw, input logic [4:0] rd,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic chk_rdata, input logic [31:0] exp_rdata,
                        input logic exp_rw, input logic exp_mis);
      item_t it;
      int    ns;
      ns = ((rd_en | wr_en) && addr[1:0] == 2'b00) ? WS : 0;
      drive(rd_en, wr_en, m2r, rw, rd, addr, wdata);
      for (int i = 0; i < ns; i++) begin
         push_bubble({tag, ".bubble"});
         @(posedge clk);
         #2;
      end
      it = '{tag: tag, stall: 1'b0, chk_alu: 1'b1, chk_rdata: chk_rdata, read_data: exp_rdata,
             alu_result: addr, rd: rd, mem_to_reg: m2r, reg_write: exp_rw, misaligned: exp_mis};
      q.push_back(it);
      @(posedge clk);
      #2;
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, ".stall"},      32'(bus.stall_out),      32'h0);
      check({tag, ".read_data"},  bus.read_data_out,       32'h0);
      check({tag, ".alu_result"}, bus.alu_result_out,      32'h0);
      check({tag, ".rd"},         32'(bus.rd_out),         32'h0);
      check({tag, ".mem_to_reg"}, 32'(bus.mem_to_reg_out), 32'h0);
      check({tag, ".reg_write"},  32'(bus.reg_write_out),  32'h0);
      check({tag, ".misaligned"}, 32'(bus.misaligned_out), 32'h0);
   endtask

   initial begin : stimulus
      reset = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
      #12;
      check_outputs_zero("reset");
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #2;

      //     tag          rd wr m2r rw rd     addr          wdata         chkrd exp_rdata     rw  mis
      issue("alu_op",     0, 0, 0,  1, 5'd7, 32'h0000_1234, 32'h0,        1,    32'h0,        1,  0);
      issue("store_10",   0, 1, 0,  0, 5'd0, 32'h0000_0010, 32'hDEADBEEF, 0,    32'h0,        0,  0);
      issue("load_10",    1, 0, 1,  1, 5'd5, 32'h0000_0010, 32'h0,        1,    32'hDEADBEEF, 1,  0);
      issue("misal_ld",   1, 0, 1,  1, 5'd6, 32'h0000_0013, 32'h0,        1,    32'h0,        0,  1);
      issue("misal_st",   0, 1, 0,  0, 5'd0, 32'h0000_0011, 32'h0,        1,    32'h0,        0,  1);
      issue("reload_10",  1, 0, 1,  1, 5'd5, 32'h0000_0010, 32'h0,        1,    32'hDEADBEEF, 1,  0);
      issue("store_400",  0, 1, 0,  0, 5'd0, 32'h0000_0400, 32'h11111111, 0,    32'h0,        0,  0);
      issue("load_0",     1, 0, 1,  1, 5'd3, 32'h0000_0000, 32'h0,        1,    32'h11111111, 1,  0);
      issue("rmw_0",      1, 1, 1,  1, 5'd9, 32'h0000_0000, 32'h22222222, 1,    32'h11111111, 1,  0);
      issue("load_0b",    1, 0, 1,  1, 5'd4, 32'h0000_0000, 32'h0,        1,    32'h22222222, 1,  0);
      issue("store_20",   0, 1, 0,  0, 5'd0, 32'h0000_0020, 32'h12345678, 0,    32'h0,        0,  0);

      // Store to 0x20 aborted by reset in the first WAIT cycle.
      drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0000_0020, 32'hAAAA5555);
      push_bubble("abort.bubble");
      @(posedge clk);
      #2;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
      #1;
      check("abort.stall_in_wait", 32'(bus.stall_out), 32'h1);
      reset = 1'b1;
      #1;
      check_outputs_zero("abort.reset");
      @(posedge clk);
      #3;
      reset = 1'b0;
      @(posedge clk);
      #2;

      issue("load_20",    1, 0, 1,  1, 5'd8, 32'h0000_0020, 32'h0,        1,    32'h12345678, 1,  0);
      issue("alu_tail",   0, 0, 0,  0, 5'd1, 32'h0000_0044, 32'h0,        1,    32'h0,        0,  0);

      repeat (3) @(posedge clk);
      check("scoreboard_empty", 32'(q.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mem_stage_wb_reg.md
Name: mem_stage_wb_reg

Overview:
- Data-memory (DM) stage of the 5-stage pipeline.
- Consumes the EX/DM pipeline register outputs: address, store data, mem_read/mem_write, mem_to_reg/reg_write, rd.
- Performs the word access against a local data memory with a configurable wait-state latency, stalling upstream while busy.
- Registers results into the DM/WB pipeline register feeding write-back.

Parameters:
- DEPTH_WORDS, 256, data memory depth in 32-bit words (power of 2).
- WAIT_STATES, 2, extra cycles per memory access (0..7).

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-high reset
- mem_read_in  in  1  load request
- mem_write_in  in  1  store request
- mem_to_reg_in  in  1  WB selects memory data
- reg_write_in  in  1  instruction writes register file
- rd_in  in  5  destination register
- mem_addr_in  in  32  byte address (ALU result)
- write_data_in  in  32  store data
- stall_out  out  1  upstream must hold EX/DM contents this cycle
- read_data_out  out  32  registered load data
- alu_result_out  out  32  registered mem_addr_in pass-through
- rd_out  out  5  registered rd
- mem_to_reg_out  out  1  registered mem_to_reg
- reg_write_out  out  1  registered reg_write
- misaligned_out  out  1  registered misaligned-access flag

Behaviour:
- Reset (async, active-high):
  - state=IDLE, cnt=0.
  - All outputs 0.
  - Memory contents are not cleared.
  - Reset during WAIT aborts the access; no store is committed.
- Word index = mem_addr_in[log2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so addresses wrap modulo the memory size.
- access = (mem_read_in | mem_write_in) & (mem_addr_in[1:0]==0).
- misaligned = (mem_read_in | mem_write_in) & (mem_addr_in[1:0]!=0).
- FSM states: IDLE and WAIT.
- IDLE, no access:
  - stall_out=0.
  - At posedge, capture inputs into the DM/WB register.
  - read_data_out=0.
  - misaligned_out=misaligned.
  - If misaligned: reg_write_out=0, no memory access, no stall.
- IDLE, access, WAIT_STATES=0:
  - Completes in one cycle with stall_out=0.
  - Store is written at that posedge.
  - Load data is registered from the pre-write array contents.
- IDLE, access, WAIT_STATES>0:
  - stall_out=1 (combinational).
  - Next state WAIT, cnt<=WAIT_STATES-1.
  - DM/WB register captures a bubble: reg_write_out=0, mem_to_reg_out=0, misaligned_out=0, read_data_out=0, rd_out=0.
- WAIT:
  - stall_out=(cnt!=0).
  - If cnt!=0: cnt decrements and another bubble is captured.
  - If cnt==0: the access completes at this posedge, exactly as in the WAIT_STATES=0 completion case, then state returns to IDLE.
- An access occupies WAIT_STATES+1 cycles, with stall_out high for the first WAIT_STATES of them.
- Inputs are required stable while stall_out=1. The block samples them only at completion.
- mem_read_in & mem_write_in both set:
  - Store is performed.
  - read_data_out returns the old word (read-before-write).
  - reg_write_out follows reg_write_in.
- Back-to-back accesses:
  - The next access is accepted in the cycle after completion.
  - A load after a store to the same word returns the new data.

Decomposition:
- Shared package dm_pkg holds:
  - state encoding (IDLE=1'b0, WAIT=1'b1)
  - WORD_BYTES=4
  - bubble constant values for the DM/WB fields
- Sub-module dm_sram:
  - DEPTH_WORDS x 32 array
  - synchronous write enable
  - combinational read
  - no reset

Test Plan:
- Store, WAIT_STATES=2: store 0xDEADBEEF to addr 0x10 -> stall_out high 2 cycles; the third posedge commits; a following load of 0x10 returns read_data_out=0xDEADBEEF with rd_out and reg_write_out=1.
- Bubbles: during the 2 stall cycles of any access -> reg_write_out=0, mem_to_reg_out=0 at each posedge, so no spurious write-back.
- Misaligned: load addr 0x13, reg_write_in=1 -> no stall, misaligned_out=1, reg_write_out=0 next cycle, memory unchanged.
- Non-memory ALU op: rd=7, addr=0x1234 -> next posedge alu_result_out=0x1234, rd_out=7, read_data_out=0, stall_out=0.
- Wrap: DEPTH_WORDS=256, store 0x11111111 to 0x400 -> a load of 0x0 returns 0x11111111.
- Async reset mid-WAIT: store 0xAAAA5555 to 0x20, assert reset in cycle 1 of WAIT -> outputs 0 immediately, state IDLE; a later load of 0x20 returns the prior contents.
